// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl: pre/post-trigger capture of a sample stream into an
// external BRAM, then a flow-controlled readout of the whole buffer.
module bram_capture_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic                  Arm,
  input  logic                  Abort,
  input  logic [ADDR_WIDTH-1:0] PostCount,
  input  logic                  InValid,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  Trigger,
  output logic                  WriteEn,
  output logic [ADDR_WIDTH-1:0] WrAddress,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [ADDR_WIDTH-1:0] RdAddress,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutLast,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRETRIG, S_ARMED, S_POST, S_READOUT
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PMAX =
    {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] p_q, p_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic [ADDR_WIDTH:0]   rcnt_q, rcnt_d;
  logic [ADDR_WIDTH:0]   xcnt_q, xcnt_d;
  logic                  done_q, done_d;
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [DATA_WIDTH-1:0] fmem_q [4];
  logic [1:0]            fwp_q, frp_q;
  logic [2:0]            fcnt_q;
  logic [2:0]            infl;
  logic [2:0]            occ;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [ADDR_WIDTH:0]   pre_tgt;
  logic                  wr_st, we, issue, xfer, push, go_rd;

  assign cnt_inc = cnt_q + 1'b1;
  assign pre_tgt = DEPTH_W - {1'b0, p_q} - 1'b1;
  assign push    = pv_q[RD_LATENCY-1];
  assign occ     = fcnt_q + infl;

  // reads currently travelling through the BRAM pipeline
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      infl = infl + {2'b00, pv_q[i]};
  end

  // next-state, counters and read/write strobes
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    ra_d    = ra_q;
    rcnt_d  = rcnt_q;
    xcnt_d  = xcnt_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    xfer    = 1'b0;
    go_rd   = 1'b0;
    wr_st   = (state_q == S_PRETRIG) ||
              (state_q == S_ARMED) ||
              (state_q == S_POST);
    we      = wr_st && InValid && !Abort;
    if (we) wa_d = wa_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (Arm) begin
          state_d = S_PRETRIG;
          p_d     = (PostCount > PMAX) ? PMAX : PostCount;
          cnt_d   = '0;
        end
      end
      S_PRETRIG: begin
        if (we) begin
          cnt_d = cnt_inc;
          if (cnt_inc == pre_tgt) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (we && Trigger) begin
          cnt_d = '0;
          if (p_q == '0) go_rd = 1'b1;
          else state_d = S_POST;
        end
      end
      S_POST: begin
        if (we) begin
          cnt_d = cnt_inc;
          if (cnt_inc == {1'b0, p_q}) go_rd = 1'b1;
        end
      end
      S_READOUT: begin
        issue = (rcnt_q != DEPTH_W) && (occ < 3'd4);
        if (issue) begin
          ra_d   = ra_q + 1'b1;
          rcnt_d = rcnt_q + 1'b1;
        end
        xfer = OutValid && OutReady;
        if (xfer) begin
          xcnt_d = xcnt_q + 1'b1;
          if (OutLast) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_rd) begin
      state_d = S_READOUT;
      ra_d    = wa_d;
      rcnt_d  = '0;
      xcnt_d  = '0;
    end
    if (Abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      issue   = 1'b0;
      xfer    = 1'b0;
    end
  end

  // FSM state, address pointers and counters
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      wa_q    <= '0;
      ra_q    <= '0;
      rcnt_q  <= '0;
      xcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
      rcnt_q  <= rcnt_d;
      xcnt_q  <= xcnt_d;
      done_q  <= done_d;
    end
  end

  // read-latency tracker: one valid bit per pipeline stage
  always_comb begin
    pv_d    = '0;
    pv_d[0] = issue;
    for (int i = 1; i < RD_LATENCY; i++)
      pv_d[i] = pv_q[i-1];
  end

  // 4-entry output FIFO fed by the read pipeline, flushed on Abort
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      pv_q   <= '0;
      fwp_q  <= '0;
      frp_q  <= '0;
      fcnt_q <= '0;
      for (int i = 0; i < 4; i++) fmem_q[i] <= '0;
    end else if (Abort) begin
      pv_q   <= '0;
      fwp_q  <= '0;
      frp_q  <= '0;
      fcnt_q <= '0;
    end else begin
      pv_q <= pv_d;
      if (push) begin
        fmem_q[fwp_q] <= RdData;
        fwp_q         <= fwp_q + 1'b1;
      end
      if (xfer) frp_q <= frp_q + 1'b1;
      fcnt_q <= fcnt_q + {2'b00, push} - {2'b00, xfer};
    end
  end

  assign WriteEn   = we;
  assign WrAddress = wa_q;
  assign WrData    = InData;
  assign RdAddress = ra_q;
  assign OutValid  = (fcnt_q != 3'd0);
  assign OutData   = fmem_q[frp_q];
  assign OutLast   = OutValid && (xcnt_q == DEPTH_W - 1'b1);
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// tb_bram_capture_ctrl: directed captures against a BRAM model,
// readout words checked by a scoreboard monitor.
module tb_bram_capture_ctrl;

  logic        Clk, rst, Arm, Abort, InValid, Trigger, OutReady;
  logic [3:0]  PostCount;
  logic [15:0] InData;
  logic        WriteEn, OutValid, OutLast, Busy, Done;
  logic [3:0]  WrAddress, RdAddress;
  logic [15:0] WrData, RdData, OutData;

  bram_capture_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_LATENCY(2)
  ) dut (
    .Clk(Clk), .rst(rst), .Arm(Arm), .Abort(Abort),
    .PostCount(PostCount), .InValid(InValid), .InData(InData),
    .Trigger(Trigger), .WriteEn(WriteEn), .WrAddress(WrAddress),
    .WrData(WrData), .RdAddress(RdAddress), .RdData(RdData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutLast(OutLast), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // BRAM model, two-cycle registered read
  logic [15:0] bmem [16];
  logic [15:0] r0, r1;
  always @(posedge Clk) begin
    if (WriteEn) bmem[WrAddress] <= WrData;
    r0 <= bmem[RdAddress];
    r1 <= r0;
  end
  assign RdData = r1;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int words_seen = 0;
  logic [16:0] exp_q [$];
  bit          hold_chk = 0;
  logic [16:0] held;

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // monitor: scoreboard pop on each transfer, stall-hold and Done count
  always @(negedge Clk) begin
    logic [16:0] e;
    if (rst) begin
      hold_chk = 0;
    end else begin
      if (Done) done_cnt++;
      if (hold_chk) begin
        chk("hold_valid", OutValid, 1);
        chk("hold_word", {OutLast, OutData}, held);
      end
      hold_chk = OutValid && !OutReady;
      held = {OutLast, OutData};
      if (OutValid && OutReady) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {OutLast, OutData}, -1);
        end else begin
          e = exp_q.pop_front();
          chk("word", {OutLast, OutData}, e);
        end
      end
    end
  end

  task automatic run(input int pc, input int trig, input int xtrig,
                     input int xarm, input bit alt, input bit stall,
                     input int first, input int abort_s,
                     input int rst_w);
    int s, st, d0;
    bit v, stop;
    if (abort_s < 0)
      for (int k = 0; k < 16; k++)
        exp_q.push_back({k == 15, 16'(first + k)});
    d0 = done_cnt;
    words_seen = 0;
    s = 0; st = 0; stop = 0;
    @(posedge Clk); #1;
    Arm = 1'b1; PostCount = 4'(pc);
    @(posedge Clk); #1;
    Arm = 1'b0;
    for (int c = 0; c < 400 && !stop; c++) begin
      v = alt ? (c % 2 == 0) : 1'b1;
      InValid = v;
      InData  = 16'(s);
      Trigger = (s == trig) || (s == xtrig);
      Arm     = v && (s == xarm);
      Abort   = v && (s == abort_s);
      OutReady = !(stall && words_seen >= 4 && st < 10);
      if (!OutReady) st++;
      if (rst_w >= 0 && words_seen >= rst_w) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_ovalid", OutValid, 0);
        chk("rst_olast", OutLast, 0);
        chk("rst_wraddr", WrAddress, 0);
        chk("rst_rdaddr", RdAddress, 0);
        exp_q.delete();
        stop = 1;
      end
      @(posedge Clk); #1;
      if (v) s++;
      if (Abort) begin
        chk("abort_busy", Busy, 0);
        chk("abort_wen", WriteEn, 0);
        stop = 1;
      end
      if (done_cnt != d0) stop = 1;
    end
    Arm = 0; Abort = 0; InValid = 0; Trigger = 0; OutReady = 1;
    rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    if (abort_s >= 0 || rst_w >= 0) begin
      chk("no_done", done_cnt, d0);
      chk("ovalid_after", OutValid, 0);
    end else begin
      chk("done_once", done_cnt, d0 + 1);
      chk("queue_empty", exp_q.size(), 0);
    end
    chk("busy_end", Busy, 0);
  endtask

  initial begin
    rst = 1'b1; Arm = 0; Abort = 0; InValid = 0; Trigger = 0;
    OutReady = 1; PostCount = '0; InData = '0;
    repeat (2) @(negedge Clk);
    chk("reset_wen", WriteEn, 0);
    chk("reset_wraddr", WrAddress, 0);
    chk("reset_rdaddr", RdAddress, 0);
    chk("reset_ovalid", OutValid, 0);
    chk("reset_olast", OutLast, 0);
    chk("reset_odata", OutData, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    @(posedge Clk); #1;
    rst = 1'b0;

    run(5, 20, -1, -1, 0, 0, 10, -1, -1);
    run(5, 20, 3, 5, 0, 0, 10, -1, -1);
    run(5, 20, -1, -1, 0, 1, 10, -1, -1);
    run(15, 5, -1, -1, 0, 0, 4, -1, -1);
    run(5, 20, -1, -1, 1, 0, 10, -1, -1);
    run(0, 16, -1, -1, 0, 0, 1, -1, -1);

    @(posedge Clk); #1;
    Arm = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1;
    Arm = 1'b0; Abort = 1'b0;
    chk("abort_over_arm", Busy, 0);

    run(5, 20, -1, -1, 0, 0, 10, 22, -1);
    run(5, 20, -1, -1, 0, 0, 10, -1, 3);
    run(5, 20, -1, -1, 0, 0, 10, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
